// File: rtl/lsu.sv
// Load/store unit: runs one request/grant/rvalid bus transaction per
// decoder load/store, aligns store data, builds byte enables, extracts and
// extends load data, and flags misaligned accesses, bus errors and timeouts.
module lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]            state_r;
  logic [1:0]            state_nx_s;
  logic                  we_r;
  logic [1:0]            type_r;
  logic                  sign_r;
  logic [1:0]            off_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  mis_r;
  logic                  err_r;
  logic                  mem_req_r;
  logic [DATA_WIDTH-1:0] mem_addr_r;
  logic                  mem_we_r;
  logic [3:0]            mem_be_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;

  logic                  misaligned_s;
  logic [3:0]            be_raw_s;
  logic [3:0]            be_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] extract_s;
  logic                  timeout_s;

  // Request decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    misaligned_s = 1'b0;
    be_raw_s     = 4'b0000;
    wdata_s      = wdata_i;
    case (data_type_i)
      2'b00: begin
        be_raw_s = 4'b0001 << addr_i[1:0];
        wdata_s  = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned_s = addr_i[0];
        be_raw_s     = 4'b0011 << addr_i[1:0];
        wdata_s      = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned_s = (addr_i[1:0] != 2'b00);
        be_raw_s     = 4'b1111;
        wdata_s      = wdata_i;
      end
      default: begin
        misaligned_s = 1'b1;
      end
    endcase
    // Loads present no byte enables on the bus; the whole word is returned.
    if (data_we_i) begin
      be_s = be_raw_s;
    end else begin
      be_s = 4'b0000;
    end
  end

  // Load data extraction: move the addressed lane down, then extend.
  always_comb begin
    shifted_s = mem_rdata_i >> {off_r, 3'b000};
    case (type_r)
      2'b00: begin
        if (sign_r) begin
          extract_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end else begin
          extract_s = {24'h000000, shifted_s[7:0]};
        end
      end
      2'b01: begin
        if (sign_r) begin
          extract_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end else begin
          extract_s = {16'h0000, shifted_s[15:0]};
        end
      end
      default: begin
        extract_s = shifted_s;
      end
    endcase
  end

  // Timeout detection: fires in the cycle the REQ/WAIT budget is used up.
  always_comb begin
    if (TIMEOUT_CYCLES > 0) begin
      timeout_s = ((state_r == REQ) || (state_r == WAIT)) && (cnt_r == CNT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state logic; a timeout takes precedence over grant or response.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (data_req_i) begin
          if (misaligned_s) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = REQ;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (timeout_s) begin
          state_nx_s = DONE;
        end else if (mem_gnt_i) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = REQ;
        end
      end
      WAIT: begin
        if (timeout_s || mem_rvalid_i) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, latched request fields, bus outputs and completion results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      type_r      <= 2'b00;
      sign_r      <= 1'b0;
      off_r       <= 2'b00;
      cnt_r       <= '0;
      done_r      <= 1'b0;
      rdata_r     <= '0;
      mis_r       <= 1'b0;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= '0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_nx_s == DONE);
      // Results are only ever non-zero during the DONE cycle.
      rdata_r <= '0;
      mis_r   <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (data_req_i) begin
            if (misaligned_s) begin
              mis_r <= 1'b1;
            end else begin
              we_r        <= data_we_i;
              type_r      <= data_type_i;
              sign_r      <= data_sign_ext_i;
              off_r       <= addr_i[1:0];
              cnt_r       <= '0;
              mem_req_r   <= 1'b1;
              mem_addr_r  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
              mem_we_r    <= data_we_i;
              mem_be_r    <= be_s;
              mem_wdata_r <= wdata_s;
            end
          end
        end
        REQ: begin
          cnt_r <= cnt_r + 1'b1;
          if (timeout_s) begin
            err_r     <= 1'b1;
            mem_req_r <= 1'b0;
          end else if (mem_gnt_i) begin
            mem_req_r <= 1'b0;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r + 1'b1;
          if (timeout_s) begin
            err_r <= 1'b1;
          end else if (mem_rvalid_i) begin
            if (mem_err_i) begin
              err_r <= 1'b1;
            end else if (!we_r) begin
              rdata_r <= extract_s;
            end
          end
        end
        DONE: begin
          mem_req_r <= 1'b0;
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = ((state_r == IDLE) && data_req_i) || (state_r == REQ) || (state_r == WAIT);
  assign done_o       = done_r;
  assign rdata_o      = rdata_r;
  assign misaligned_o = mis_r;
  assign bus_err_o    = err_r;
  assign mem_req_o    = mem_req_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_we_o     = mem_we_r;
  assign mem_be_o     = mem_be_r;
  assign mem_wdata_o  = mem_wdata_r;

endmodule
